uart_tx: RTL

Serial UART transmitter that turns one parallel byte into a framed bit stream: start bit, DATA_WIDTH data bits LSB first, an optional parity bit, and a stop bit. It is the transmit end of the team's UART link and produces exactly the frame format that UART_RX decodes. It runs on the transmit clock, which is the receive clock divided by Prescale, so each serial bit lasts one CLK cycle. An upstream register file or FIFO drives P_DATA with a Data_Valid pulse. TX_OUT goes to the serial line.

---
 rtl/uart_tx.sv | 114 +++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// One serial bit per CLK cycle; TX_OUT and busy come straight from flops.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  // Outputs are computed for the state being entered, so the registered
  // TX_OUT shows each bit during the cycle that follows its edge.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = 1'b1;
    busy_d    = 1'b1;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (Data_Valid) begin
          state_d   = START;
          shift_d   = P_DATA;
          par_en_d  = PAR_EN;
          par_bit_d = PAR_TYP ^ (^P_DATA);
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
      end
      DATA: begin
        if (cnt_q == LAST_BIT) begin
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_bit_q;
          end else begin
            state_d = STOP;
          end
        end else begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        state_d = STOP;
      end
      STOP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule
